// File: rtl/sd_arb_pkg.sv
// Shared types and helpers for the memory-sharing arbiter: slot index type,
// class encodings and a rotate-and-find-first-set search.
package sd_arb_pkg;

    localparam int SLOT_W  = 6;
    localparam int MAX_REQ = 1 << SLOT_W;

    localparam logic CLS_WR = 1'b0;
    localparam logic CLS_RD = 1'b1;

    typedef logic [SLOT_W-1:0] slot_idx_t;

    typedef struct packed {
        logic      valid;
        slot_idx_t idx;
    } pick_t;

    // First set bit of req[0..n-1] searching upward from start, wrapping at n.
    function automatic pick_t rr_find(input logic [MAX_REQ-1:0] req,
                                      input int                 n,
                                      input int                 start);
        pick_t r;
        int    k;
        r.valid = 1'b0;
        r.idx   = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            k = start + i;
            if (k >= n) k = k - n;
            if (i < n && k < n && !r.valid && req[k]) begin
                r.valid = 1'b1;
                r.idx   = slot_idx_t'(k);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sd_mem_share_arb_if.sv
// Request/grant/memory bundle between the FIFO controllers, the arbiter and
// the shared RAM. slave = arbiter side, master = controllers + RAM side.
interface sd_mem_share_arb_if #(
    parameter int nq    = 4,
    parameter int width = 8,
    parameter int asz   = 6
);
    logic [nq-1:0]       wr_req;
    logic [nq*asz-1:0]   wr_addr;
    logic [nq*width-1:0] wr_data;
    logic [nq-1:0]       wr_grant;
    logic [nq-1:0]       rd_req;
    logic [nq*asz-1:0]   rd_addr;
    logic [nq-1:0]       rd_grant;
    logic [asz-1:0]      mem_addr;
    logic                mem_we;
    logic                mem_re;
    logic [width-1:0]    mem_wr_data;
    logic [width-1:0]    mem_rd_data;
    logic [nq-1:0]       rd_valid;
    logic [width-1:0]    rd_data;

    // Grants are a pure function of requests and registered pointers; a
    // request must therefore never depend combinationally on its grant.
    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_rd_data,
        output wr_grant, rd_grant, mem_addr, mem_we, mem_re, mem_wr_data,
               rd_valid, rd_data
    );

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_rd_data,
        input  wr_grant, rd_grant, mem_addr, mem_we, mem_re, mem_wr_data,
               rd_valid, rd_data
    );
endinterface

// File: rtl/sd_rr_pick.sv
// Round-robin picker: one-hot grant and index of the first request at or
// above the start pointer, wrapping modulo N.
module sd_rr_pick #(
    parameter int N  = 8,
    parameter int SW = 3
) (
    input  logic [N-1:0]  req_i,
    input  logic [SW-1:0] start_i,
    output logic [N-1:0]  gnt_o,
    output logic [SW-1:0] idx_o,
    output logic          valid_o
);
    import sd_arb_pkg::*;

    logic [MAX_REQ-1:0] req_ext;
    pick_t              pick;

    always_comb begin
        req_ext         = '0;
        req_ext[N-1:0]  = req_i;
        pick            = rr_find(req_ext, N, int'(start_i));
        valid_o         = pick.valid;
        idx_o           = SW'(pick.idx);
        gnt_o           = '0;
        if (pick.valid) gnt_o[idx_o] = 1'b1;
    end

endmodule

// File: rtl/sd_mem_share_arb.sv
// Shares one 1RW RAM between nq FIFO heads and tails. Define
// SDLIB_ARB_WRPRI_EN to give writes strict priority over reads.
module sd_mem_share_arb #(
    parameter int nq    = 4,
    parameter int width = 8,
    parameter int depth = 64,
    parameter int asz   = $clog2(depth),
    parameter int qsz   = (nq > 1) ? $clog2(nq) : 1
) (
    input  logic              clk,
    input  logic              reset,
    sd_mem_share_arb_if.slave bus
);
    import sd_arb_pkg::*;

    logic           gnt_vld;
    logic           gnt_cls;
    logic [qsz-1:0] gnt_q;
    logic [nq-1:0]  cls_wr_oh;
    logic [nq-1:0]  cls_rd_oh;

`ifdef SDLIB_ARB_WRPRI_EN
    logic [qsz-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [qsz-1:0] wr_idx, rd_idx;
    logic           wr_vld, rd_vld;

    sd_rr_pick #(.N(nq), .SW(qsz)) u_pick_wr (
        .req_i(bus.wr_req), .start_i(wr_ptr_q),
        .gnt_o(cls_wr_oh), .idx_o(wr_idx), .valid_o(wr_vld)
    );

    sd_rr_pick #(.N(nq), .SW(qsz)) u_pick_rd (
        .req_i(bus.rd_req), .start_i(rd_ptr_q),
        .gnt_o(cls_rd_oh), .idx_o(rd_idx), .valid_o(rd_vld)
    );

    // Any write beats every read; each class rotates on its own grants only.
    always_comb begin
        gnt_vld  = (wr_vld | rd_vld) & ~reset;
        gnt_cls  = wr_vld ? CLS_WR : CLS_RD;
        gnt_q    = wr_vld ? wr_idx : rd_idx;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (gnt_vld && gnt_cls == CLS_WR)
            wr_ptr_d = (wr_idx == qsz'(nq - 1)) ? '0 : wr_idx + qsz'(1);
        if (gnt_vld && gnt_cls == CLS_RD)
            rd_ptr_d = (rd_idx == qsz'(nq - 1)) ? '0 : rd_idx + qsz'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
`else
    localparam int NS = 2 * nq;

    logic [qsz:0]  rr_ptr_q, rr_ptr_d;
    logic [qsz:0]  slot_idx;
    logic [NS-1:0] slot_gnt;
    logic          slot_vld;

    sd_rr_pick #(.N(NS), .SW(qsz + 1)) u_pick (
        .req_i({bus.rd_req, bus.wr_req}), .start_i(rr_ptr_q),
        .gnt_o(slot_gnt), .idx_o(slot_idx), .valid_o(slot_vld)
    );

    // Slots [0,nq) are heads, [nq,2nq) are tails; wrap is explicit because
    // 2*nq need not be a power of two.
    always_comb begin
        gnt_vld   = slot_vld & ~reset;
        gnt_cls   = (slot_idx >= (qsz+1)'(nq)) ? CLS_RD : CLS_WR;
        gnt_q     = (gnt_cls == CLS_RD) ? qsz'(slot_idx - (qsz+1)'(nq))
                                        : qsz'(slot_idx);
        cls_wr_oh = slot_gnt[nq-1:0];
        cls_rd_oh = slot_gnt[NS-1:nq];
        rr_ptr_d  = rr_ptr_q;
        if (gnt_vld)
            rr_ptr_d = (slot_idx == (qsz+1)'(NS - 1)) ? '0
                                                      : slot_idx + (qsz+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) rr_ptr_q <= '0;
        else       rr_ptr_q <= rr_ptr_d;
    end
`endif

    always_comb begin
        bus.wr_grant    = '0;
        bus.rd_grant    = '0;
        bus.mem_we      = 1'b0;
        bus.mem_re      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wr_data = '0;
        if (gnt_vld) begin
            if (gnt_cls == CLS_WR) begin
                bus.wr_grant    = cls_wr_oh;
                bus.mem_we      = 1'b1;
                bus.mem_addr    = bus.wr_addr[gnt_q*asz +: asz];
                bus.mem_wr_data = bus.wr_data[gnt_q*width +: width];
            end else begin
                bus.rd_grant    = cls_rd_oh;
                bus.mem_re      = 1'b1;
                bus.mem_addr    = bus.rd_addr[gnt_q*asz +: asz];
            end
        end
    end

    // Read return: the RAM answers one cycle after mem_re, tag remembers who asked.
    logic           rd_pend_q, rd_pend_d;
    logic [qsz-1:0] rd_tag_q, rd_tag_d;

    always_comb begin
        rd_pend_d = bus.mem_re;
        rd_tag_d  = (gnt_vld && gnt_cls == CLS_RD) ? gnt_q : rd_tag_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend_q <= 1'b0;
            rd_tag_q  <= '0;
        end else begin
            rd_pend_q <= rd_pend_d;
            rd_tag_q  <= rd_tag_d;
        end
    end

    always_comb begin
        bus.rd_valid = '0;
        if (rd_pend_q && !reset) bus.rd_valid[rd_tag_q] = 1'b1;
        bus.rd_data = bus.mem_rd_data;
    end

endmodule

// File: tb/tb_sd_mem_share_arb.sv
// Directed bench for sd_mem_share_arb (default unified round-robin build).
module tb_sd_mem_share_arb;
    localparam int NQ = 4, W = 8, DEPTH = 64, ASZ = 6;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    sd_mem_share_arb_if #(.nq(NQ), .width(W), .asz(ASZ)) bus ();

    sd_mem_share_arb #(.nq(NQ), .width(W), .depth(DEPTH)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic chk_port(input string tag, input logic [3:0] wg, input logic [3:0] rg,
                            input logic we, input logic re, input logic [5:0] addr,
                            input logic [7:0] wd, input bit chk_wd);
        chk({tag, "_wg"},   32'(bus.wr_grant), 32'(wg));
        chk({tag, "_rg"},   32'(bus.rd_grant), 32'(rg));
        chk({tag, "_we"},   32'(bus.mem_we),   32'(we));
        chk({tag, "_re"},   32'(bus.mem_re),   32'(re));
        chk({tag, "_addr"}, 32'(bus.mem_addr), 32'(addr));
        if (chk_wd) chk({tag, "_wd"}, 32'(bus.mem_wr_data), 32'(wd));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] w, input logic [3:0] r);
        bus.wr_req = w;
        bus.rd_req = r;
    endtask

    initial begin
        int slot, prev, q, prevq;
        logic [3:0] wg, rg, rv;
        logic [5:0] addr;
        logic [7:0] wd;

        reset = 1'b1;
        set_req(4'hF, 4'hF);
        bus.mem_rd_data = '0;
        for (int i = 0; i < NQ; i++) begin
            bus.wr_addr[i*ASZ +: ASZ] = 6'(16 + i);
            bus.rd_addr[i*ASZ +: ASZ] = 6'(32 + i);
            bus.wr_data[i*W +: W]     = 8'(48 + i);
        end
        tick;

        // Reset masks grants even with every request up.
        for (int c = 0; c < 3; c++) begin
            #1;
            chk_port("rst", 4'h0, 4'h0, 1'b0, 1'b0, 6'h0, 8'h0, 1'b1);
            chk("rst_rv", 32'(bus.rd_valid), 32'h0);
            tick;
        end

        reset = 1'b0;
        set_req(4'h0, 4'h0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk_port("idle", 4'h0, 4'h0, 1'b0, 1'b0, 6'h0, 8'h0, 1'b1);
            chk("idle_rv", 32'(bus.rd_valid), 32'h0);
            tick;
        end

        // All eight slots requesting: strict rotation 0..7, twice.
        set_req(4'hF, 4'hF);
        prev = -1;
        for (int c = 0; c < 16; c++) begin
            slot = c % 8;
            bus.mem_rd_data = 8'(128 + c);
            #1;
            if (slot < 4) begin
                wg = 4'(1 << slot); rg = 4'h0;
                addr = 6'(16 + slot); wd = 8'(48 + slot);
                chk_port("rr", wg, rg, 1'b1, 1'b0, addr, wd, 1'b1);
            end else begin
                wg = 4'h0; rg = 4'(1 << (slot - 4));
                addr = 6'(32 + slot - 4); wd = 8'h0;
                chk_port("rr", wg, rg, 1'b0, 1'b1, addr, wd, 1'b0);
            end
            rv = (prev >= 4) ? 4'(1 << (prev - 4)) : 4'h0;
            chk("rr_rv", 32'(bus.rd_valid), 32'(rv));
            chk("rr_rd", 32'(bus.rd_data), 32'(128 + c));
            prev = slot;
            tick;
        end
        set_req(4'h0, 4'h0);
        #1;
        chk("rr_tail_rv", 32'(bus.rd_valid), 32'h8);
        chk_port("rr_tail", 4'h0, 4'h0, 1'b0, 1'b0, 6'h0, 8'h0, 1'b1);
        tick;

        // Single read of queue 2 at 0x15, data 0xA5 returns one cycle later.
        bus.rd_addr[2*ASZ +: ASZ] = 6'h15;
        set_req(4'h0, 4'b0100);
        #1;
        chk_port("rd2", 4'h0, 4'b0100, 1'b0, 1'b1, 6'h15, 8'h0, 1'b0);
        tick;
        set_req(4'h0, 4'h0);
        bus.mem_rd_data = 8'hA5;
        #1;
        chk("rd2_rv", 32'(bus.rd_valid), 32'b0100);
        chk("rd2_rd", 32'(bus.rd_data), 32'hA5);
        chk_port("rd2_idle", 4'h0, 4'h0, 1'b0, 1'b0, 6'h0, 8'h0, 1'b1);
        tick;

        // Pointer now 7: tails 3 and 1 alternate, starting with 3, no bubbles.
        set_req(4'h0, 4'b1010);
        prevq = -1;
        for (int c = 0; c < 6; c++) begin
            q = (c % 2 == 0) ? 3 : 1;
            bus.mem_rd_data = 8'(64 + c);
            #1;
            chk_port("alt", 4'h0, 4'(1 << q), 1'b0, 1'b1, 6'(32 + q), 8'h0, 1'b0);
            if (prevq >= 0) begin
                chk("alt_rv", 32'(bus.rd_valid), 32'(1 << prevq));
                chk("alt_rd", 32'(bus.rd_data), 32'(64 + c));
            end
            prevq = q;
            tick;
        end
        set_req(4'h0, 4'h0);
        #1;
        chk("alt_tail_rv", 32'(bus.rd_valid), 32'b0010);
        tick;

        // Read granted, then reset: no rd_valid, pointer back to slot 0.
        set_req(4'h0, 4'b0001);
        #1;
        chk_port("prerst", 4'h0, 4'b0001, 1'b0, 1'b1, 6'(32), 8'h0, 1'b0);
        tick;
        reset = 1'b1;
        set_req(4'hF, 4'hF);
        #1;
        chk("midrst_rv", 32'(bus.rd_valid), 32'h0);
        chk_port("midrst", 4'h0, 4'h0, 1'b0, 1'b0, 6'h0, 8'h0, 1'b1);
        tick;
        reset = 1'b0;
        #1;
        chk_port("postrst", 4'b0001, 4'h0, 1'b1, 1'b0, 6'h10, 8'h30, 1'b1);
        chk("postrst_rv", 32'(bus.rd_valid), 32'h0);
        tick;

        // Same queue on both sides: head slot 2 goes before tail slot 6.
        set_req(4'b0100, 4'b0100);
        #1;
        chk_port("both_w", 4'b0100, 4'h0, 1'b1, 1'b0, 6'h12, 8'h32, 1'b1);
        tick;
        #1;
        chk_port("both_r", 4'h0, 4'b0100, 1'b0, 1'b1, 6'h15, 8'h0, 1'b0);
        tick;
        set_req(4'h0, 4'h0);
        bus.mem_rd_data = 8'h5A;
        #1;
        chk("both_rv", 32'(bus.rd_valid), 32'b0100);
        chk("both_rd", 32'(bus.rd_data), 32'h5A);
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
